// File: rtl/pcm_sched_pkg.sv
// Shared types for the PCM-to-SPI scheduler: FSM state encodings and sample geometry.
package pcm_sched_pkg;

    typedef enum logic {
        W_IDLE,
        W_MSB
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SEND
    } rd_state_t;

    localparam int BYTES_PER_SAMPLE = 2;

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer for an asynchronous level with a single-cycle rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign rise_o = (sync_q[2:1] == 2'b01);

endmodule

// File: rtl/pcm_spi_scheduler.sv
// Splits PCM samples into LSB/MSB byte pairs for the TX FIFO and serves SPI byte requests from it.
module pcm_spi_scheduler
    import pcm_sched_pkg::*;
#(
    parameter int         SAMPLE_W  = 16,
    parameter logic [7:0] FILL_BYTE = 8'h00,
    parameter int         CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] pcm_data,
    input  logic                pcm_valid,
    input  logic                fifo_full,
    input  logic                fifo_almost_full,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_rd_data,
    output logic                fifo_wr_en,
    output logic [7:0]          fifo_wr_data,
    output logic                fifo_rd_en,
    input  logic                spi_busy,
    output logic [7:0]          spi_data,
    output logic                spi_valid,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    underrun_cnt
);

    localparam int BYTE_W = SAMPLE_W / BYTES_PER_SAMPLE;

    wr_state_t         wr_state_q, wr_state_d;
    logic [BYTE_W-1:0] msb_q, msb_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic              rd_en_q, rd_en_d;
    logic [7:0]        spi_data_q, spi_data_d;
    logic              spi_valid_q, spi_valid_d;
    logic [CNT_W-1:0]  under_q, under_d;

    logic              busy_rise;

    edge_sync u_busy_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_busy),
        .rise_o  (busy_rise)
    );

    // Only the MSB is held; the LSB goes straight from pcm_data into the first write.
    always_comb begin
        wr_state_d = wr_state_q;
        msb_d      = msb_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        drop_d     = drop_q;
        case (wr_state_q)
            W_IDLE: begin
                if (pcm_valid && en) begin
                    if (!fifo_almost_full && !fifo_full) begin
                        msb_d      = pcm_data[SAMPLE_W-1:BYTE_W];
                        wr_en_d    = 1'b1;
                        wr_data_d  = pcm_data[BYTE_W-1:0];
                        wr_state_d = W_MSB;
                    end else if (drop_q != '1) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                end
            end
            W_MSB: begin
                wr_en_d    = 1'b1;
                wr_data_d  = msb_q;
                wr_state_d = W_IDLE;
                if (pcm_valid && en && (drop_q != '1)) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            msb_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            drop_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            msb_q      <= msb_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            drop_q     <= drop_d;
        end
    end

    // FETCH waits out the FIFO read latency; SEND captures the byte and pulses valid together.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_en_d     = 1'b0;
        spi_data_d  = spi_data_q;
        spi_valid_d = 1'b0;
        under_d     = under_q;
        case (rd_state_q)
            R_IDLE: begin
                if (busy_rise) begin
                    if (fifo_empty) begin
                        spi_data_d  = FILL_BYTE;
                        spi_valid_d = 1'b1;
                        if (under_q != '1) begin
                            under_d = under_q + CNT_W'(1);
                        end
                    end else begin
                        rd_en_d    = 1'b1;
                        rd_state_d = R_FETCH;
                    end
                end
            end
            R_FETCH: rd_state_d = R_SEND;
            R_SEND: begin
                spi_data_d  = fifo_rd_data;
                spi_valid_d = 1'b1;
                rd_state_d  = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= R_IDLE;
            rd_en_q     <= 1'b0;
            spi_data_q  <= FILL_BYTE;
            spi_valid_q <= 1'b0;
            under_q     <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_en_q     <= rd_en_d;
            spi_data_q  <= spi_data_d;
            spi_valid_q <= spi_valid_d;
            under_q     <= under_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_en_q;
    assign spi_data     = spi_data_q;
    assign spi_valid    = spi_valid_q;
    assign drop_cnt     = drop_q;
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_pcm_spi_scheduler.sv
// Randomized bench for pcm_spi_scheduler against a cycle-indexed transaction model and a FIFO model.
module tb_pcm_spi_scheduler;

    localparam int         DEPTH = 64;
    localparam logic [7:0] FILL  = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pcm_valid = 1'b0;
    logic        spi_busy = 1'b0;
    logic        force_af = 1'b0;
    logic [15:0] pcm_data = '0;
    logic        fifo_full, fifo_almost_full, fifo_empty;
    logic [7:0]  fifo_rd_data = '0;
    logic        fifo_wr_en, fifo_rd_en, spi_valid;
    logic [7:0]  fifo_wr_data, spi_data;
    logic [15:0] drop_cnt, underrun_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fq_cnt = 0;
    logic [7:0] fq[$];

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_wr[$];
    logic [7:0] mfifo[$];
    logic [7:0] obs_spi[$];
    int         last_acc = -10;
    int         rd_cyc = -1;
    int         spi_cyc = -1;
    int         uf_cyc = -1;
    int         rd_free = 0;
    logic [7:0] spi_exp_byte = 8'h00;
    logic [7:0] m_spi = FILL;
    int         m_drop = 0;
    int         m_under = 0;
    logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    pcm_spi_scheduler #(
        .SAMPLE_W  (16),
        .FILL_BYTE (FILL),
        .CNT_W     (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .pcm_data         (pcm_data),
        .pcm_valid        (pcm_valid),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_empty       (fifo_empty),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_rd_en       (fifo_rd_en),
        .spi_busy         (spi_busy),
        .spi_data         (spi_data),
        .spi_valid        (spi_valid),
        .drop_cnt         (drop_cnt),
        .underrun_cnt     (underrun_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty       = (fq_cnt == 0);
    assign fifo_full        = (fq_cnt >= DEPTH);
    assign fifo_almost_full = force_af || (fq_cnt >= DEPTH - 1);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Byte FIFO with one-cycle read latency, as seen by the scheduler.
    initial begin
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
            if (fifo_wr_en === 1'b1) fq.push_back(fifo_wr_data);
            if (fifo_rd_en === 1'b1) fifo_rd_data <= (fq.size() != 0) ? fq.pop_front() : 8'hEE;
            fq_cnt <= fq.size();
        end
    end

    // Reference: decisions at cycle c use FIFO occupancy during c; strobes land at end of c.
    task automatic model_step();
        int   c;
        bit   e_wr, e_rd, e_sv, edge_now, af;
        ev_t  ev;
        c = cyc;
        if (!rst_n) begin
            check_eq("rst_wr_en", 32'(fifo_wr_en), 0);
            check_eq("rst_wr_data", 32'(fifo_wr_data), 0);
            check_eq("rst_rd_en", 32'(fifo_rd_en), 0);
            check_eq("rst_spi_valid", 32'(spi_valid), 0);
            check_eq("rst_spi_data", 32'(spi_data), 32'(FILL));
            check_eq("rst_drop", 32'(drop_cnt), 0);
            check_eq("rst_under", 32'(underrun_cnt), 0);
            exp_wr.delete();
            rd_cyc = -1; spi_cyc = -1; uf_cyc = -1; rd_free = 0;
            last_acc = -10; m_spi = FILL; m_drop = 0; m_under = 0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            return;
        end

        e_wr = (exp_wr.size() != 0) && (exp_wr[0].c == c);
        check_eq("wr_en", 32'(fifo_wr_en), 32'(e_wr));
        if (e_wr) check_eq("wr_data", 32'(fifo_wr_data), 32'(exp_wr[0].d));
        e_rd = (rd_cyc == c);
        check_eq("rd_en", 32'(fifo_rd_en), 32'(e_rd));
        if (spi_cyc == c) m_spi = spi_exp_byte;
        if (uf_cyc == c)  m_spi = FILL;
        e_sv = (spi_cyc == c) || (uf_cyc == c);
        check_eq("spi_valid", 32'(spi_valid), 32'(e_sv));
        check_eq("spi_data", 32'(spi_data), 32'(m_spi));
        if (spi_valid === 1'b1) obs_spi.push_back(spi_data);
        check_eq("drop_cnt", 32'(drop_cnt), m_drop);
        check_eq("underrun_cnt", 32'(underrun_cnt), m_under);

        edge_now = h2 && !h3;
        if (edge_now && c >= rd_free) begin
            if (mfifo.size() == 0) begin
                uf_cyc = c + 1;
                if (m_under < 65535) m_under++;
            end else begin
                rd_cyc  = c + 1;
                spi_cyc = c + 3;
                rd_free = c + 3;
            end
        end
        if (pcm_valid && en) begin
            af = force_af || (DEPTH - mfifo.size() <= 1);
            if (c == last_acc + 1 || af) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                exp_wr.push_back('{c + 1, pcm_data[7:0]});
                exp_wr.push_back('{c + 2, pcm_data[15:8]});
                last_acc = c;
            end
        end

        if (e_wr) begin
            ev = exp_wr.pop_front();
            mfifo.push_back(ev.d);
        end
        if (e_rd) spi_exp_byte = (mfifo.size() != 0) ? mfifo.pop_front() : 8'hEE;
        h3 = h2; h2 = h1; h1 = spi_busy;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_pcm(input logic [15:0] d);
        pcm_data  = d;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
    endtask

    task automatic preload(input logic [7:0] b);
        fq.push_back(b);
        mfifo.push_back(b);
    endtask

    initial begin
        int pre;
        int hold;
        idle(3);
        rst_n = 1'b1;
        en    = 1'b1;
        idle(3);
        check_eq("post_rst_drop", 32'(drop_cnt), 0);

        pulse_pcm(16'hA55A);
        idle(4);
        check_eq("pair_count", fq.size(), 2);
        check_eq("pair_lsb", 32'(fq[0]), 32'h5A);
        check_eq("pair_msb", 32'(fq[1]), 32'hA5);
        check_eq("pair_drop", 32'(drop_cnt), 0);

        repeat (2) begin
            spi_busy = 1'b1; idle(8);
            spi_busy = 1'b0; idle(8);
        end
        check_eq("fetch_count", obs_spi.size(), 2);
        check_eq("fetch_b0", 32'(obs_spi[0]), 32'h5A);
        check_eq("fetch_b1", 32'(obs_spi[1]), 32'hA5);
        check_eq("fetch_drained", fq.size(), 0);

        spi_busy = 1'b1; idle(8);
        spi_busy = 1'b0; idle(8);
        check_eq("underrun_cnt1", 32'(underrun_cnt), 1);
        check_eq("underrun_byte", 32'(obs_spi[2]), 32'(FILL));

        preload(8'h3C);
        idle(2);
        spi_busy = 1'b1;
        idle(2);
        pulse_pcm(16'hBEEF);
        idle(6);
        spi_busy = 1'b0;
        idle(8);
        check_eq("conc_read", 32'(obs_spi[3]), 32'h3C);
        check_eq("conc_count", fq.size(), 2);
        check_eq("conc_lsb", 32'(fq[0]), 32'hEF);
        check_eq("conc_msb", 32'(fq[1]), 32'hBE);

        pre = fq.size();
        pulse_pcm(16'h1357);
        tick();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(5);
        check_eq("midpair_count", fq.size(), pre + 1);
        check_eq("midpair_lsb", 32'(fq[fq.size() - 1]), 32'h57);
        check_eq("midpair_under", 32'(underrun_cnt), 0);

        pre = fq.size();
        force_af = 1'b1;
        pulse_pcm(16'h1234);
        idle(2);
        check_eq("af_drop1", 32'(drop_cnt), 1);
        check_eq("af_nowrite", fq.size(), pre);
        pcm_valid = 1'b1;
        repeat (65538) tick();
        pcm_valid = 1'b0;
        idle(2);
        check_eq("drop_sat", 32'(drop_cnt), 32'hFFFF);
        force_af = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        hold = 5;
        for (int i = 0; i < 3000; i++) begin
            pcm_data  = 16'($urandom);
            pcm_valid = ($urandom_range(0, 2) == 0);
            en        = ($urandom_range(0, 15) != 0);
            force_af  = ($urandom_range(0, 19) == 0);
            hold--;
            if (hold <= 0) begin
                spi_busy = ~spi_busy;
                hold = $urandom_range(4, 15);
            end
            tick();
        end
        pcm_valid = 1'b0;
        force_af  = 1'b0;
        spi_busy  = 1'b0;
        idle(20);
        check_eq("final_fifo_size", fq.size(), mfifo.size());
        for (int i = 0; i < fq.size() && i < mfifo.size(); i++) begin
            check_eq("final_fifo_byte", 32'(fq[i]), 32'(mfifo[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
